// File: rtl/periph_bus_pkg.sv
// Shared types and helpers for the two-master peripheral bus arbiter.
package periph_bus_pkg;

  // Transaction sequencer states: arbitrate, strobe the slave, acknowledge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  // Encoding of the grant output: which master owns the current transaction.
  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DMA = 1'b1;

  // The DMA master wins when it holds the burst lock, when it has been starved
  // long enough, or simply when the CPU is not asking. Otherwise the CPU wins.
  function automatic logic pick_dma(input logic cpu_req,
                                    input logic dma_req,
                                    input logic locked,
                                    input logic starved);
    return dma_req & (locked | starved | ~cpu_req);
  endfunction

endpackage : periph_bus_pkg

// File: rtl/periph_bus_arbiter.sv
// Two-master arbiter/sequencer for the shared peripheral bus. Each access is
// serialised into a 3-cycle IDLE -> XFER -> DONE transaction: registered slave
// address/data/strobe in XFER, registered read data and a one-cycle ack in
// DONE. The CPU (master 0) has fixed priority; the DMA engine (master 1) gets a
// starvation escape after MAX_WAIT lost arbitrations and can lock the bus for
// back-to-back bursts.
module periph_bus_arbiter
  import periph_bus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 4
) (
  input  logic              sysclk,
  input  logic              reset,

  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_rd,
  input  logic              m0_wr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_stall,

  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_rd,
  input  logic              m1_wr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,

  output logic [ADDR_W-1:0] s_addr,
  output logic              s_rd,
  output logic              s_wr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,

  output logic              grant
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  // Sequencer and arbitration state
  state_e              state_q,    state_d;
  logic                grant_q,    grant_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                lock_q,     lock_d;

  // Registered slave-side outputs
  logic [ADDR_W-1:0]   s_addr_q,   s_addr_d;
  logic [DATA_W-1:0]   s_wdata_q,  s_wdata_d;
  logic                s_rd_q,     s_rd_d;
  logic                s_wr_q,     s_wr_d;

  // Registered master-side outputs
  logic                m0_ack_q,   m0_ack_d;
  logic                m1_ack_q,   m1_ack_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

  // Arbitration result for the current IDLE cycle
  logic                any_req;
  logic                starved;
  logic                pick_m1;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_rd;
  logic                sel_wr;
  logic [DATA_W-1:0]   captured;

  // Decide which master would win if the bus were sampled now, and mux its request.
  always_comb begin
    any_req   = m0_req | m1_req;
    starved   = (wait_cnt_q == WAIT_LIMIT);
    pick_m1   = pick_dma(m0_req, m1_req, lock_q, starved);
    sel_addr  = pick_m1 ? m1_addr  : m0_addr;
    sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
    sel_rd    = pick_m1 ? m1_rd    : m0_rd;
    sel_wr    = pick_m1 ? m1_wr    : m0_wr;
  end

  // All state registers; asynchronous assert, release is taken on a clock edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its _d; blocking here would create order-dependent races.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      // NOTE: every register, data paths included, is reset so the bus comes up
      // with no strobe, no ack and deterministic read data.
      state_q    <= IDLE;
      grant_q    <= GRANT_CPU;
      wait_cnt_q <= '0;
      lock_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_rd_q     <= 1'b0;
      s_wr_q     <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      wait_cnt_q <= wait_cnt_d;
      lock_q     <= lock_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_rd_q     <= s_rd_d;
      s_wr_q     <= s_wr_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Next state, grant owner, starvation counter and burst lock.
  always_comb begin
    // NOTE: each variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    grant_d    = grant_q;
    wait_cnt_d = wait_cnt_q;
    lock_d     = lock_q;

    case (state_q)
      IDLE: begin
        // The lock only survives while the DMA keeps requesting and keeps winning.
        if (!m1_req || (m0_req && !pick_m1)) begin
          lock_d = 1'b0;
        end
        if (any_req) begin
          state_d = XFER;
          grant_d = pick_m1 ? GRANT_DMA : GRANT_CPU;
          if (pick_m1) begin
            wait_cnt_d = '0;
          end else if (m1_req && !starved) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      XFER: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        lock_d  = (grant_q == GRANT_DMA) & m1_lock;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs: latch the winner's request, strobe for one cycle, ack for one cycle.
  always_comb begin
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_rd_d     = 1'b0;
    s_wr_d     = 1'b0;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    // Only a real read returns slave data; writes and empty accesses return zero.
    captured   = s_rd_q ? s_rdata : '0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          s_addr_d  = sel_addr;
          s_wdata_d = sel_wdata;
          s_wr_d    = sel_wr;
          s_rd_d    = sel_rd & ~sel_wr;  // a write always beats a simultaneous read
        end
      end
      XFER: begin
        if (grant_q == GRANT_DMA) begin
          m1_ack_d   = 1'b1;
          m1_rdata_d = captured;
        end else begin
          m0_ack_d   = 1'b1;
          m0_rdata_d = captured;
        end
      end
      default: begin
      end
    endcase
  end

  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_rd     = s_rd_q;
  assign s_wr     = s_wr_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign grant    = grant_q;
  assign m0_stall = m0_req & ~m0_ack_q;

endmodule : periph_bus_arbiter
